// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_arbiter
// Brief    : Two-requester round-robin arbiter driving a single APB master
//            port, with optional ACCESS-phase timeout abort.
// Revision : 1.0  initial release
// ============================================================================
module apb_rr_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [1:0]        req,
    input  logic [1:0]        wr_req,
    input  logic [ADDR_W-1:0] addr_req0,
    input  logic [ADDR_W-1:0] addr_req1,
    input  logic [DATA_W-1:0] data_send0,
    input  logic [DATA_W-1:0] data_send1,
    output logic [DATA_W-1:0] data_reciv,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic [1:0]        grant,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // Counter only ever has to hold TIMEOUT-1; the abort fires on that value.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_pick1;
    logic w_timeout;

    // r_ptr = 1 means requester 1 currently holds priority.
    assign w_pick1   = req[1] & (~req[0] | r_ptr);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_cnt      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            data_reciv <= '0;
            ack        <= 2'b00;
            err        <= 2'b00;
            grant      <= 2'b00;
        end else begin
            ack <= 2'b00;
            err <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant   <= w_pick1 ? 2'b10 : 2'b01;
                        r_ptr   <= ~w_pick1;
                        pwrite  <= w_pick1 ? wr_req[1]  : wr_req[0];
                        paddr   <= w_pick1 ? addr_req1  : addr_req0;
                        pwdata  <= w_pick1 ? data_send1 : data_send0;
                        psel    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        if (!pwrite) begin
                            data_reciv <= prdata;
                        end
                        ack     <= grant;
                        grant   <= 2'b00;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        ack     <= grant;
                        err     <= grant;
                        grant   <= 2'b00;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_apb_rr_arbiter
// Brief    : Scoreboard bench for apb_rr_arbiter with a programmable APB slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_rr_arbiter;

    logic       clk = 1'b0;
    logic       preset;
    logic [1:0] req, wr_req;
    logic [7:0] addr_req0, addr_req1, data_send0, data_send1;
    logic [7:0] data_reciv, paddr, pwdata, prdata;
    logic [1:0] ack, err, grant;
    logic       pwrite, psel, penable, pready;

    always #5 clk = ~clk;

    apb_rr_arbiter #(.TIMEOUT(4), .ADDR_W(8), .DATA_W(8)) u_dut (
        .pclk(clk), .preset(preset), .req(req), .wr_req(wr_req),
        .addr_req0(addr_req0), .addr_req1(addr_req1),
        .data_send0(data_send0), .data_send1(data_send1),
        .data_reciv(data_reciv), .ack(ack), .err(err), .grant(grant),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    typedef struct {
        logic [1:0] who;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         acc;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         acks[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         s_waits = 0;
    logic [7:0] s_rdata = 8'h00;
    logic [7:0] exp_rdata = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // APB slave: inserts s_waits wait states, drives garbage prdata until ready.
    initial begin
        int wc;
        wc = 0;
        pready = 1'b1;
        prdata = 8'hEE;
        forever begin
            @(posedge clk);
            #1;
            if (!psel) begin
                pready = 1'b1;
                prdata = 8'hEE;
            end else if (!penable) begin
                wc = 0;
                pready = 1'b1;
                prdata = 8'hEE;
            end else begin
                pready = (wc >= s_waits);
                prdata = pready ? s_rdata : 8'hEE;
                wc++;
            end
        end
    end

    // Monitor: checks SETUP contents, ACCESS stability and completions.
    initial begin
        int   acc;
        exp_t e;
        acc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (psel && !penable) begin
                acc = 0;
                if (sb.size() == 0) begin
                    check_val("spurious_setup", sb.size(), 1);
                end else begin
                    check_val("setup_grant", grant, sb[0].who);
                    check_val("setup_paddr", paddr, sb[0].addr);
                    check_val("setup_pwrite", pwrite, sb[0].wr);
                    if (sb[0].wr) check_val("setup_pwdata", pwdata, sb[0].wdata);
                end
            end
            if (psel && penable) begin
                acc++;
                if (sb.size() != 0) begin
                    check_val("access_paddr", paddr, sb[0].addr);
                    check_val("access_grant", grant, sb[0].who);
                end
            end
            if (ack != 2'b00) begin
                acks.push_back(cyc);
                if (sb.size() == 0) begin
                    check_val("spurious_ack", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_val("ack_owner", ack, e.who);
                    check_val("err_flag", err, e.err ? e.who : 2'b00);
                    check_val("access_cycles", acc, e.acc);
                    check_val("psel_after", {grant, psel, penable}, 4'b0000);
                    if (!e.wr && !e.err) exp_rdata = e.rd;
                    check_val("data_reciv", data_reciv, exp_rdata);
                end
            end else if (err != 2'b00) begin
                check_val("err_without_ack", err, 2'b00);
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic xfer(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rd, input int acc, input logic er);
        exp_t e;
        int   n;
        @(negedge clk);
        s_waits = waits;
        s_rdata = rd;
        wr_req[id] = wr;
        if (id == 0) begin
            addr_req0 = a; data_send0 = d;
        end else begin
            addr_req1 = a; data_send1 = d;
        end
        req[id] = 1'b1;
        e.who = (id == 0) ? 2'b01 : 2'b10;
        e.wr = wr; e.addr = a; e.wdata = d; e.rd = rd; e.acc = acc; e.err = er;
        sb.push_back(e);
        n = 0;
        while (!grant[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("grant_seen", grant[id], 1'b1);
        req[id] = 1'b0;
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n, k;
        preset = 1'b1; req = 2'b00; wr_req = 2'b00;
        addr_req0 = 8'h00; addr_req1 = 8'h00; data_send0 = 8'h00; data_send1 = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_psel", psel, 1'b0);
        check_val("rst_penable", penable, 1'b0);
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_ack_err", {ack, err}, 4'b0000);
        check_val("rst_data_reciv", data_reciv, 8'h00);
        check_val("rst_paddr_pwdata", {paddr, pwdata, pwrite}, 17'h0);
        req = 2'b11;
        repeat (2) @(negedge clk);
        check_val("req_ignored_in_reset", {psel, grant}, 3'b000);
        req = 2'b00;
        preset = 1'b0;

        // Zero-wait write from requester 0, then 2-wait read from requester 1.
        xfer(0, 1'b1, 8'h0A, 8'hF1, 0, 8'h00, 1, 1'b0);
        xfer(1, 1'b0, 8'h0A, 8'h00, 2, 8'h5C, 3, 1'b0);

        // Both requesting from reset: strict alternation 0,1,0,1.
        @(negedge clk);
        preset = 1'b1;
        exp_rdata = 8'h00;
        s_waits = 0; s_rdata = 8'h44;
        wr_req = 2'b01;
        addr_req0 = 8'h11; data_send0 = 8'h22;
        addr_req1 = 8'h33; data_send1 = 8'h00;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            e.who = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.wr = (i % 2 == 0);
            e.addr = (i % 2 == 0) ? 8'h11 : 8'h33;
            e.wdata = (i % 2 == 0) ? 8'h22 : 8'h00;
            e.rd = 8'h44; e.acc = 1; e.err = 1'b0;
            sb.push_back(e);
        end
        @(negedge clk);
        acks.delete();
        preset = 1'b0;
        n = 0; k = 0;
        while (k < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (psel && !penable) k++;
        end
        req = 2'b00;
        wait_done();
        check_val("ack_count", acks.size(), 4);
        if (acks.size() >= 4) begin
            for (int i = 0; i < 3; i++) check_val("ack_gap", acks[i+1] - acks[i], 3);
        end

        // Timeout abort (TIMEOUT=4), then a normal transfer.
        xfer(0, 1'b0, 8'h55, 8'h00, 1000, 8'hAB, 4, 1'b1);
        xfer(1, 1'b1, 8'h77, 8'h88, 0, 8'h00, 1, 1'b0);
        // pready arriving exactly on the timeout cycle completes normally.
        xfer(0, 1'b0, 8'h66, 8'h00, 3, 8'h99, 4, 1'b0);

        // Reset during ACCESS: transfer dropped silently.
        @(negedge clk);
        s_waits = 1000; s_rdata = 8'h12;
        wr_req[0] = 1'b0; addr_req0 = 8'h21; req[0] = 1'b1;
        e.who = 2'b01; e.wr = 1'b0; e.addr = 8'h21; e.wdata = 8'h00; e.rd = 8'h12; e.acc = 0; e.err = 1'b0;
        sb.push_back(e);
        n = 0;
        while (!penable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_access", penable, 1'b1);
        req = 2'b00;
        @(negedge clk);
        preset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_val("mid_rst_apb", {psel, penable, grant}, 4'b0000);
        check_val("mid_rst_ack_err", {ack, err}, 4'b0000);
        check_val("mid_rst_data", data_reciv, 8'h00);
        exp_rdata = 8'h00;
        preset = 1'b0;
        xfer(1, 1'b0, 8'h3C, 8'h00, 0, 8'hC3, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
